// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter: LSU has priority over IFU,
// one outstanding transaction, response timeout forces an error completion.
module mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ifu_req,
  input  logic [DATA_WIDTH-1:0]   ifu_addr,
  output logic                    ifu_gnt,
  output logic                    ifu_rvalid,
  output logic [DATA_WIDTH-1:0]   ifu_rdata,
  input  logic                    lsu_req,
  input  logic                    lsu_wen,
  input  logic [DATA_WIDTH-1:0]   lsu_addr,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_wmask,
  output logic                    lsu_gnt,
  output logic                    lsu_rvalid,
  output logic [DATA_WIDTH-1:0]   lsu_rdata,
  output logic                    err,
  output logic                    mem_req,
  output logic                    mem_wen,
  output logic [DATA_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic                    mem_ready,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam int MW = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE, REQ_IF, REQ_LS, WAIT_IF, WAIT_LS
  } state_e;

  state_e                state_q;
  logic                  wen_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [MW-1:0]         wmask_q;
  logic [CW-1:0]         cnt_q;

  logic is_req, is_wait, is_ls;
  logic limit, resp, tmo, done;

  always_comb begin
    is_req  = (state_q == REQ_IF) || (state_q == REQ_LS);
    is_wait = (state_q == WAIT_IF) || (state_q == WAIT_LS);
    is_ls   = (state_q == REQ_LS) || (state_q == WAIT_LS);
    limit   = (cnt_q == CW'(TIMEOUT - 1));
    // a real response on the limit cycle beats the timeout
    resp    = is_wait && mem_rvalid;
    tmo     = (is_req || is_wait) && limit && !resp;
    done    = resp || tmo;
  end

  always_comb begin
    lsu_gnt    = !rst && (state_q == IDLE) && lsu_req;
    ifu_gnt    = !rst && (state_q == IDLE) && ifu_req && !lsu_req;
    ifu_rvalid = !rst && done && !is_ls;
    lsu_rvalid = !rst && done && is_ls;
    err        = !rst && tmo;
    ifu_rdata  = '0;
    lsu_rdata  = '0;
    if (ifu_rvalid && resp) ifu_rdata = mem_rdata;
    if (lsu_rvalid && resp && !wen_q) lsu_rdata = mem_rdata;
    mem_req    = !rst && is_req;
    mem_wen    = mem_req && wen_q;
    mem_addr   = mem_req ? addr_q  : '0;
    mem_wdata  = mem_req ? wdata_q : '0;
    mem_wmask  = mem_req ? wmask_q : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (lsu_req) begin
            state_q <= REQ_LS;
            wen_q   <= lsu_wen;
            addr_q  <= lsu_addr;
            wdata_q <= lsu_wdata;
            wmask_q <= lsu_wmask;
          end else if (ifu_req) begin
            state_q <= REQ_IF;
            wen_q   <= 1'b0;
            addr_q  <= ifu_addr;
            wdata_q <= '0;
            wmask_q <= '0;
          end
        end
        REQ_IF, REQ_LS: begin
          cnt_q <= cnt_q + CW'(1);
          if (tmo) state_q <= IDLE;
          else if (mem_ready)
            state_q <= is_ls ? WAIT_LS : WAIT_IF;
        end
        WAIT_IF, WAIT_LS: begin
          cnt_q <= cnt_q + CW'(1);
          if (done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table plus scoreboard on DUT A,
// timeout corner cases on DUT B built with TIMEOUT=4.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ifu_req;
  logic [31:0] ifu_addr;
  logic        lsu_req;
  logic        lsu_wen;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        a_ifu_gnt, a_ifu_rvalid, a_lsu_gnt, a_lsu_rvalid, a_err;
  logic [31:0] a_ifu_rdata, a_lsu_rdata, a_mem_addr, a_mem_wdata;
  logic        a_mem_req, a_mem_wen;
  logic [3:0]  a_mem_wmask;

  logic        b_ifu_gnt, b_ifu_rvalid, b_lsu_gnt, b_lsu_rvalid, b_err;
  logic [31:0] b_ifu_rdata, b_lsu_rdata, b_mem_addr, b_mem_wdata;
  logic        b_mem_req, b_mem_wen;
  logic [3:0]  b_mem_wmask;

  mem_arbiter #(.DATA_WIDTH(32), .TIMEOUT(255)) dut_a (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr),
    .ifu_gnt(a_ifu_gnt), .ifu_rvalid(a_ifu_rvalid),
    .ifu_rdata(a_ifu_rdata),
    .lsu_req(lsu_req), .lsu_wen(lsu_wen),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_wmask(lsu_wmask),
    .lsu_gnt(a_lsu_gnt), .lsu_rvalid(a_lsu_rvalid),
    .lsu_rdata(a_lsu_rdata), .err(a_err),
    .mem_req(a_mem_req), .mem_wen(a_mem_wen),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_wmask(a_mem_wmask),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.DATA_WIDTH(32), .TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr),
    .ifu_gnt(b_ifu_gnt), .ifu_rvalid(b_ifu_rvalid),
    .ifu_rdata(b_ifu_rdata),
    .lsu_req(lsu_req), .lsu_wen(lsu_wen),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_wmask(lsu_wmask),
    .lsu_gnt(b_lsu_gnt), .lsu_rvalid(b_lsu_rvalid),
    .lsu_rdata(b_lsu_rdata), .err(b_err),
    .mem_req(b_mem_req), .mem_wen(b_mem_wen),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_wmask(b_mem_wmask),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        lsu;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          dly;
    logic [31:0] mrdata;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic        lsu;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[5];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Response monitor for DUT A: every rvalid must match a queued expectation.
  always @(negedge clk) begin
    if (a_ifu_rvalid || a_lsu_rvalid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rvalid: got ifu=%b lsu=%b expected none at %0t",
                 a_ifu_rvalid, a_lsu_rvalid, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rvalid_owner", {31'b0, a_lsu_rvalid}, {31'b0, e.lsu});
        chk("rvalid_both", {31'b0, a_ifu_rvalid & a_lsu_rvalid}, 32'd0);
        chk("rdata", e.lsu ? a_lsu_rdata : a_ifu_rdata, e.data);
        chk("rvalid_err", {31'b0, a_err}, 32'd0);
      end
    end
  end

  task automatic run_txn(vec_t v);
    if (v.lsu) begin
      lsu_req   = 1'b1;
      lsu_wen   = v.wen;
      lsu_addr  = v.addr;
      lsu_wdata = v.wdata;
      lsu_wmask = v.wmask;
    end else begin
      ifu_req   = 1'b1;
      ifu_addr  = v.addr;
      lsu_wdata = v.wdata;
      lsu_wmask = v.wmask;
    end
    @(negedge clk);
    chk(v.lsu ? "lsu_gnt" : "ifu_gnt",
        {31'b0, v.lsu ? a_lsu_gnt : a_ifu_gnt}, 32'd1);
    sb.push_back('{lsu: v.lsu, data: v.exp});
    step();
    ifu_req = 1'b0;
    lsu_req = 1'b0;
    for (int d = 0; d <= v.dly; d++) begin
      mem_ready = (d == v.dly);
      @(negedge clk);
      chk("mem_req", {31'b0, a_mem_req}, 32'd1);
      chk("mem_addr", a_mem_addr, v.addr);
      chk("mem_wen", {31'b0, a_mem_wen}, {31'b0, v.lsu & v.wen});
      chk("mem_wdata", a_mem_wdata, v.lsu ? v.wdata : 32'd0);
      chk("mem_wmask", {28'b0, a_mem_wmask}, {28'b0, v.lsu ? v.wmask : 4'd0});
      step();
    end
    mem_ready  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = v.mrdata;
    @(negedge clk);
    chk("resp_seen", {31'b0, a_ifu_rvalid | a_lsu_rvalid}, 32'd1);
    chk("resp_mem_req", {31'b0, a_mem_req}, 32'd0);
    step();
    mem_rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h8000_0000, 32'h1111_2222, 4'h3, 0,
                32'h0000_0413, 32'h0000_0413};
    vecs[1] = '{1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 3,
                32'hCAFE_F00D, 32'h0000_0000};
    vecs[2] = '{1'b1, 1'b0, 32'h8000_1000, 32'h0000_0000, 4'h0, 1,
                32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 1'b1, 32'h8000_1002, 32'h0000_AB00, 4'h2, 0,
                32'h5555_5555, 32'h0000_0000};
    vecs[4] = '{1'b0, 1'b0, 32'h8000_0004, 32'h0000_0000, 4'h0, 2,
                32'hFFFF_FFFF, 32'hFFFF_FFFF};

    rst = 1'b1;
    ifu_req = 1'b1; ifu_addr = 32'h8000_0000;
    lsu_req = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h1234;
    lsu_wdata = 32'h5678; lsu_wmask = 4'hF;
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    @(negedge clk);
    chk("rst_ifu_gnt", {31'b0, a_ifu_gnt}, 32'd0);
    chk("rst_lsu_gnt", {31'b0, a_lsu_gnt}, 32'd0);
    chk("rst_mem_req", {31'b0, a_mem_req}, 32'd0);
    chk("rst_mem_addr", a_mem_addr, 32'd0);
    chk("rst_err", {31'b0, a_err}, 32'd0);
    step();
    rst = 1'b0;
    ifu_req = 1'b0; lsu_req = 1'b0; lsu_wen = 1'b0;
    mem_ready = 1'b0; mem_rvalid = 1'b0;

    foreach (vecs[i]) run_txn(vecs[i]);

    // simultaneous requests: LSU first, IFU granted right after completion
    lsu_req = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_3000;
    ifu_req = 1'b1; ifu_addr = 32'h8000_0010;
    @(negedge clk);
    chk("sim_lsu_gnt", {31'b0, a_lsu_gnt}, 32'd1);
    chk("sim_ifu_gnt", {31'b0, a_ifu_gnt}, 32'd0);
    sb.push_back('{lsu: 1'b1, data: 32'hA5A5_0001});
    step();
    lsu_req = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    chk("sim_mem_addr_ls", a_mem_addr, 32'h8000_3000);
    chk("sim_no_gnt_req", {31'b0, a_ifu_gnt}, 32'd0);
    step();
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_0001;
    @(negedge clk);
    chk("sim_no_gnt_wait", {31'b0, a_ifu_gnt}, 32'd0);
    step();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("sim_ifu_gnt_t3", {31'b0, a_ifu_gnt}, 32'd1);
    sb.push_back('{lsu: 1'b0, data: 32'h0010_0073});
    step();
    ifu_req = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    chk("sim_mem_addr_if", a_mem_addr, 32'h8000_0010);
    step();
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0010_0073;
    step();
    mem_rvalid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;

    // timeout on DUT B: memory never accepts
    lsu_req = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_4000;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("tmo_gnt", {31'b0, b_lsu_gnt}, 32'd1);
    step();
    lsu_req = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("tmo_mem_req", {31'b0, b_mem_req}, 32'd1);
      chk("tmo_rvalid", {31'b0, b_lsu_rvalid}, {31'b0, i == 4});
      chk("tmo_err", {31'b0, b_err}, {31'b0, i == 4});
      if (i == 4) chk("tmo_rdata", b_lsu_rdata, 32'd0);
      step();
    end
    @(negedge clk);
    chk("tmo_idle_req", {31'b0, b_mem_req}, 32'd0);
    chk("tmo_idle_rv", {31'b0, b_lsu_rvalid}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;

    // response exactly on the timeout cycle (DUT A completes in step too)
    lsu_req = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_5000;
    @(negedge clk);
    chk("lim_gnt", {31'b0, b_lsu_gnt}, 32'd1);
    sb.push_back('{lsu: 1'b1, data: 32'h1234_5678});
    step();
    lsu_req = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    chk("lim_mem_req", {31'b0, b_mem_req}, 32'd1);
    step();
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("lim_early_rv", {31'b0, b_lsu_rvalid}, 32'd0);
      step();
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("lim_rvalid", {31'b0, b_lsu_rvalid}, 32'd1);
    chk("lim_rdata", b_lsu_rdata, 32'h1234_5678);
    chk("lim_err", {31'b0, b_err}, 32'd0);
    step();
    mem_rvalid = 1'b0;

    // reset during WAIT_IF, late response must be dropped
    ifu_req = 1'b1; ifu_addr = 32'h8000_0100;
    @(negedge clk);
    chk("rmt_gnt", {31'b0, a_ifu_gnt}, 32'd1);
    step();
    ifu_req = 1'b0; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rmt_rst_req", {31'b0, a_mem_req}, 32'd0);
    chk("rmt_rst_rv", {31'b0, a_ifu_rvalid}, 32'd0);
    step();
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_0000;
    @(negedge clk);
    chk("rmt_late_rv", {31'b0, a_ifu_rvalid}, 32'd0);
    chk("rmt_late_err", {31'b0, a_err}, 32'd0);
    chk("rmt_late_data", a_ifu_rdata, 32'd0);
    step();
    mem_rvalid = 1'b0;
    run_txn(vecs[0]);

    step();
    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
